// File: rtl/lut_interp_pkg.sv
// Shared constants and helpers for the LUT interpolating activation unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lut_interp_pkg;

  // Encodings for the top-segment behaviour.
  localparam int WRAP  = 1;  // top segment interpolates toward lut[0]
  localparam int CLAMP = 0;  // top segment is flat at lut[last]

  // Power-on ramp: entry i holds i scaled to the top of the DATA_W range.
  // The caller truncates to DATA_W, so the upper half of the table reads as
  // negative values (0,16,...,112,-128,...,-16 for the default widths).
  function automatic logic [31:0] lut_reset_value(input int i, input int data_w, input int addr_w);
    return 32'(i) << (data_w - addr_w);
  endfunction

endpackage

// File: rtl/lut_interp_regfile.sv
// LUT storage: one synchronous write port, combinational base/next read with wrap/clamp on the top entry.
// Latency: reads are combinational; a write becomes visible to reads after the clock edge.
// Backpressure: none; writes are always taken.
module lut_interp_regfile
  import lut_interp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int WRAP_MODE = WRAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Table storage: reset restores the ramp (reset beats a coincident write).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(lut_reset_value(i, DATA_W, ADDR_W));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Segment endpoints; the top segment either wraps to entry 0 or stays flat.
  always_comb begin
    base = mem[raddr];
    next = mem[raddr];
    if (raddr == LAST) begin
      next = (WRAP_MODE == WRAP) ? mem[0] : mem[LAST];
    end else begin
      next = mem[raddr + ADDR_W'(1)];
    end
  end

endmodule

// File: rtl/lut_interp_activation.sv
// Activation unit: signed sample -> LUT segment lookup -> linear interpolation between segment endpoints.
// Latency: 3 cycles from input accept to out_valid; one sample per cycle when unstalled.
// Backpressure: the whole pipeline freezes while out_valid is held without out_ready; in_ready drops with it.
module lut_interp_activation
  import lut_interp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int FRAC_W    = 4,
  parameter int WRAP_MODE = WRAP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W+FRAC_W-1:0]   x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   y,
  input  logic                       cfg_we,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic signed [DATA_W-1:0]   cfg_data
);

  localparam int IN_W   = ADDR_W + FRAC_W;
  // diff needs DATA_W+1 bits; times an unsigned FRAC_W fraction, plus headroom.
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic                     adv;
  logic [ADDR_W-1:0]        idx;
  logic [FRAC_W-1:0]        frac_in;
  logic signed [DATA_W-1:0] lut_base;
  logic signed [DATA_W-1:0] lut_next;

  // Stage 1 registers (lookup)
  logic                     v1;
  logic signed [DATA_W-1:0] base1;
  logic signed [DATA_W-1:0] next1;
  logic [FRAC_W-1:0]        frac1;
  // Stage 2 registers (multiply)
  logic                     v2;
  logic signed [DATA_W-1:0] base2;
  logic signed [PROD_W-1:0] prod2;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] diff_ext;
  logic signed [PROD_W-1:0] frac_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] sum;
  logic                     sum_fits;

  // Single advance enable: every stage moves together or not at all.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign idx      = x[IN_W-1:FRAC_W];
  assign frac_in  = x[FRAC_W-1:0];

  lut_interp_regfile #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .WRAP_MODE (WRAP_MODE)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx),
    .base  (lut_base),
    .next  (lut_next)
  );

  // Segment slope times fraction; the fraction is zero-extended so it stays non-negative.
  always_comb begin
    diff     = $signed({next1[DATA_W-1], next1}) - $signed({base1[DATA_W-1], base1});
    diff_ext = PROD_W'(diff);
    frac_ext = PROD_W'($signed({1'b0, frac1}));
    prod     = diff_ext * frac_ext;
  end

  // Arithmetic shift floors the scaled product, keeping the result between the endpoints.
  always_comb begin
    sum      = PROD_W'(base2) + (prod2 >>> FRAC_W);
    sum_fits = (sum[PROD_W-1:DATA_W-1] == '0) || (sum[PROD_W-1:DATA_W-1] == '1);
  end

  // Three-stage pipeline; data registers load only behind a valid so y holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      base1     <= '0;
      next1     <= '0;
      frac1     <= '0;
      base2     <= '0;
      prod2     <= '0;
      y         <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        base1 <= lut_base;
        next1 <= lut_next;
        frac1 <= frac_in;
      end
      v2 <= v1;
      if (v1) begin
        base2 <= base1;
        prod2 <= prod;
      end
      out_valid <= v2;
      if (v2) begin
        y <= sum[DATA_W-1:0];
      end
    end
  end

  // The interpolated value is bounded by its endpoints, so truncation must never lose bits.
  always_ff @(posedge clk) begin
    if (!rst && adv && v2) begin
      assert (sum_fits);
    end
  end

endmodule

// File: tb/tb_lut_interp_activation.sv
module tb_lut_interp_activation;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        x;
  logic              out_ready;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic signed [7:0] cfg_data;

  logic              in_ready, in_ready_c;
  logic              out_valid, out_valid_c;
  logic signed [7:0] y, y_c;

  int    n_cmp;
  int    n_err;
  int    n_out;
  int    exp_w[$];
  int    exp_c[$];
  bit    rand_ready;
  string cur_tag;
  logic signed [7:0] tb_lut [16];

  lut_interp_activation #(.DATA_W(8), .ADDR_W(4), .FRAC_W(4), .WRAP_MODE(1)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  lut_interp_activation #(.DATA_W(8), .ADDR_W(4), .FRAC_W(4), .WRAP_MODE(0)) dut_clamp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .x(x),
    .out_valid(out_valid_c), .out_ready(out_ready), .y(y_c),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d outputs", n_out);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: base + floor((next-base)*frac/16), with explicit floor for negatives.
  function automatic int model_y(input logic [7:0] xv, input bit wrap);
    int idx = int'(xv[7:4]);
    int f   = int'(xv[3:0]);
    int b, n, num, q;
    b = tb_lut[idx];
    if (idx == 15) n = wrap ? tb_lut[0] : tb_lut[15];
    else           n = tb_lut[idx + 1];
    num = (n - b) * f;
    q   = num / 16;
    if ((num < 0) && (num % 16 != 0)) q = q - 1;
    return b + q;
  endfunction

  // Called at a negedge; returns at the negedge after the sample was accepted.
  task automatic send(input logic [7:0] xv, input int ew, input int ec);
    int waited = 0;
    in_valid = 1'b1;
    x        = xv;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check_val("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_w.push_back(ew);
      exp_c.push_back(ec);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_w.size() != 0 && k < 300) begin
      @(negedge clk);
      #2;
      k++;
    end
    check_val({cur_tag, "_drain"}, exp_w.size(), 0);
    @(negedge clk);
  endtask

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Output monitor: in-order scoreboard for both instances plus stall stability.
  initial begin
    bit                hold_pending;
    logic signed [7:0] held_y;
    hold_pending = 1'b0;
    held_y       = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold_pending = 1'b0;
        continue;
      end
      if (out_valid_c !== out_valid) check_val("vld_pair", out_valid_c, out_valid);
      if (hold_pending) begin
        check_val({cur_tag, "_hold_vld"}, out_valid, 1);
        check_val({cur_tag, "_hold_y"}, y, held_y);
      end
      if (out_valid) begin
        if (out_ready) begin
          hold_pending = 1'b0;
          if (exp_w.size() == 0) begin
            check_val({cur_tag, "_unexpected_out"}, 1, 0);
          end else begin
            check_val({cur_tag, "_y_wrap"}, y, exp_w.pop_front());
            check_val({cur_tag, "_y_clamp"}, y_c, exp_c.pop_front());
            n_out++;
          end
        end else begin
          hold_pending = 1'b1;
          held_y       = y;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    int start_out;
    n_cmp = 0; n_err = 0; n_out = 0;
    rand_ready = 1'b0;
    cur_tag  = "reset";
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    out_ready = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    for (int i = 0; i < 16; i++) tb_lut[i] = (i < 8) ? 8'(i * 16) : 8'(i * 16 - 256);

    // Reset held for a few cycles with a coincident table write: reset must win.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 8'sd100;
    repeat (3) @(negedge clk);
    cfg_we = 1'b0;
    rst    = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_y", y, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_y_clamp", y_c, 0);
    @(negedge clk);

    // 1: first-sample latency and value.
    cur_tag   = "t1";
    out_ready = 1'b1;
    send(8'h12, 18, 18);
    #1; check_val("t1_lat1", out_valid, 0);
    @(negedge clk); #1; check_val("t1_lat2", out_valid, 0);
    @(negedge clk); #1; check_val("t1_lat3", out_valid, 1);
    @(negedge clk);
    drain();

    // 2: top segment wrap vs clamp, and a segment crossing the sign boundary.
    cur_tag = "t2";
    send(8'hF8, -8, -16);
    send(8'h7F, -113, -113);
    send(8'hF0, -16, -16);
    send(8'hFF, -1, -16);
    send(8'h00, 0, 0);
    drain();

    // 6a: zero fraction returns the table entry exactly.
    cur_tag = "t6a";
    for (int i = 0; i < 16; i++) begin
      send(8'(i << 4), (i < 8) ? i * 16 : i * 16 - 256, (i < 8) ? i * 16 : i * 16 - 256);
    end
    drain();

    // 4: write in the same cycle as a lookup sees the old entry; later lookups see the new one.
    cur_tag  = "t4";
    cfg_we   = 1'b1; cfg_addr = 4'd1; cfg_data = 8'sd100;
    send(8'h18, 24, 24);
    cfg_we   = 1'b0;
    send(8'h10, 100, 100);
    send(8'h18, 66, 66);
    send(8'h08, 50, 50);
    drain();

    // 5: reset with three samples in flight and downstream stalled.
    cur_tag   = "t5";
    out_ready = 1'b0;
    send(8'h12, 18, 18);
    send(8'h22, 34, 34);
    send(8'h32, 50, 50);
    #1; check_val("t5_stalled_vld", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_w.delete();
    exp_c.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; check_val("t5_no_vld_after_rst", out_valid, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'h18, 24, 24);
    drain();

    // 3: full input sweep under random backpressure.
    cur_tag    = "t3";
    start_out  = n_out;
    rand_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), model_y(8'(i), 1'b1), model_y(8'(i), 1'b0));
    end
    drain();
    check_val("t3_count", n_out - start_out, 256);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);

    // 6b: random table writes interleaved with random samples.
    cur_tag = "t6b";
    for (int i = 0; i < 80; i++) begin
      bit                w;
      logic [3:0]        wa;
      logic signed [7:0] wd;
      logic [7:0]        xv;
      int                ew, ec;
      w  = ($urandom_range(0, 1) == 1);
      wa = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      xv = 8'($urandom_range(0, 255));
      ew = model_y(xv, 1'b1);
      ec = model_y(xv, 1'b0);
      cfg_we = w; cfg_addr = wa; cfg_data = wd;
      send(xv, ew, ec);
      cfg_we = 1'b0;
      if (w) tb_lut[wa] = wd;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
